// File: rtl/secure_scrub_ram.sv
// secure_scrub_ram: secure scratch RAM with per-entry occupancy bits and hardware
// zeroization on reset, global zeroize and per-entry release.
// Optional feature macro: SECURE_SCRUB_READBACK_EN adds a VERIFY pass after every
// full scrub that reads back each word and flags a sticky scrub_fail on any nonzero word.
module secure_scrub_ram #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              rel_valid,
    input  logic [ADDR_W-1:0] rel_addr,
    input  logic              zeroize,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              busy,
    output logic              scrub_done,
    output logic              scrub_fail
);

    typedef enum logic [1:0] {
        SCRUB_ALL = 2'd0,
        VERIFY    = 2'd1,
        IDLE      = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   scrub_ptr_q, scrub_ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                scrub_done_q, scrub_done_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    occ_q;

    // Single write port shared by scrub, release and accepted writes
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_occ;

`ifdef SECURE_SCRUB_READBACK_EN
    logic                fail_set;
    logic                scrub_fail_q, scrub_fail_d;
`endif

    // Next-state, write-port selection and read response computation
    always_comb begin
        state_d      = state_q;
        scrub_ptr_d  = scrub_ptr_q;
        req_ready    = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = scrub_ptr_q;
        wr_data      = '0;
        wr_occ       = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_hit_d    = 1'b0;
        rsp_data_d   = '0;
`ifdef SECURE_SCRUB_READBACK_EN
        fail_set     = 1'b0;
`endif
        case (state_q)
            SCRUB_ALL: begin
                wr_en = 1'b1;
                if (zeroize) begin
                    scrub_ptr_d = '0;
                end else begin
                    scrub_ptr_d = scrub_ptr_q + ADDR_W'(1);
                    if (scrub_ptr_q == ADDR_W'(DEPTH - 1)) begin
`ifdef SECURE_SCRUB_READBACK_EN
                        state_d = VERIFY;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef SECURE_SCRUB_READBACK_EN
            VERIFY: begin
                fail_set = (mem_q[scrub_ptr_q] != '0);
                if (zeroize) begin
                    state_d     = SCRUB_ALL;
                    scrub_ptr_d = '0;
                end else begin
                    scrub_ptr_d = scrub_ptr_q + ADDR_W'(1);
                    if (scrub_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            IDLE: begin
                req_ready = !zeroize && !rel_valid;
                if (zeroize) begin
                    state_d     = SCRUB_ALL;
                    scrub_ptr_d = '0;
                end else if (rel_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = rel_addr;
                end else if (req_valid && req_we) begin
                    wr_en   = 1'b1;
                    wr_addr = req_addr;
                    wr_data = req_wdata;
                    wr_occ  = 1'b1;
                end else if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = occ_q[req_addr];
                    rsp_data_d  = occ_q[req_addr] ? mem_q[req_addr] : '0;
                end
            end
            default: begin
                state_d     = SCRUB_ALL;
                scrub_ptr_d = '0;
            end
        endcase
        scrub_done_d = (state_q != IDLE) && (state_d == IDLE);
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SCRUB_ALL;
            scrub_ptr_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_data_q   <= '0;
            scrub_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scrub_ptr_q  <= scrub_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_data_q   <= rsp_data_d;
            scrub_done_q <= scrub_done_d;
        end
    end

    // Occupancy bits, cleared by reset and by every scrub/release write
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else if (wr_en) begin
            occ_q[wr_addr] <= wr_occ;
        end
    end

    // Data array has no reset; the post-reset scrub pass clears it
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef SECURE_SCRUB_READBACK_EN
    // Sticky readback failure flag, cleared only by reset
    always_comb begin
        scrub_fail_d = scrub_fail_q | fail_set;
    end

    // Readback failure register
    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_fail_q <= 1'b0;
        end else begin
            scrub_fail_q <= scrub_fail_d;
        end
    end

    assign scrub_fail = scrub_fail_q;
`else
    assign scrub_fail = 1'b0;
`endif

    assign busy       = (state_q != IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_data   = rsp_data_q;
    assign scrub_done = scrub_done_q;

endmodule

// File: tb/tb_secure_scrub_ram.sv
// tb_secure_scrub_ram: table-driven directed vectors, hand-written scrub/reset
// sequences and a randomized phase checked against an array-based reference model.
`timescale 1ns/1ps
module tb_secure_scrub_ram;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
`ifdef SECURE_SCRUB_READBACK_EN
    localparam int TOTAL = 2 * DEPTH;
`else
    localparam int TOTAL = DEPTH;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rel_valid;
    logic [ADDR_W-1:0] rel_addr;
    logic              zeroize;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_hit;
    logic              busy;
    logic              scrub_done;
    logic              scrub_fail;

    secure_scrub_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rel_valid(rel_valid), .rel_addr(rel_addr), .zeroize(zeroize),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .busy(busy), .scrub_done(scrub_done), .scrub_fail(scrub_fail)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rel_valid = 1'b0; rel_addr = '0; zeroize = 1'b0;
    endtask

    // Called just after the edge that starts a scrub; counts busy cycles and done pulses
    task automatic count_busy(output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int c = 0; c < 2 * TOTAL + 8; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (scrub_done) nd++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 4 * TOTAL) begin
            @(negedge clk);
            guard++;
        end
        chk1("wait_idle_timeout", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_REL} op_e;
    typedef struct {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              exp_hit;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    localparam logic [DATA_W-1:0] DB   = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    localparam logic [DATA_W-1:0] P55  = 128'h55555555_55555555_55555555_55555555;
    localparam logic [DATA_W-1:0] CAFE = 128'h0000CAFE_00000000_00000000_0000F00D;

    vec_t tbl[14];

    // Reference model state for the randomized phase
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_occ [DEPTH];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd;
        logic prev_rd;
        vec_t prev;
        logic [DATA_W-1:0] fill;

        tbl[0]  = '{OP_WR,  4'd3,  DB,   1'b0, '0};
        tbl[1]  = '{OP_RD,  4'd3,  '0,   1'b1, DB};
        tbl[2]  = '{OP_RD,  4'd4,  '0,   1'b0, '0};
        tbl[3]  = '{OP_WR,  4'd5,  P55,  1'b0, '0};
        tbl[4]  = '{OP_REL, 4'd5,  '0,   1'b0, '0};
        tbl[5]  = '{OP_RD,  4'd5,  '0,   1'b0, '0};
        tbl[6]  = '{OP_WR,  4'd15, '1,   1'b0, '0};
        tbl[7]  = '{OP_RD,  4'd15, '0,   1'b1, '1};
        tbl[8]  = '{OP_WR,  4'd0,  128'h1, 1'b0, '0};
        tbl[9]  = '{OP_WR,  4'd3,  CAFE, 1'b0, '0};
        tbl[10] = '{OP_RD,  4'd3,  '0,   1'b1, CAFE};
        tbl[11] = '{OP_RD,  4'd0,  '0,   1'b1, 128'h1};
        tbl[12] = '{OP_REL, 4'd3,  '0,   1'b0, '0};
        tbl[13] = '{OP_RD,  4'd3,  '0,   1'b0, '0};

        // ---- reset values and post-reset scrub length ----
        idle_inputs();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_hit", rsp_hit, 1'b0);
        chkw("rst_rsp_data", rsp_data, '0);
        chk1("rst_scrub_done", scrub_done, 1'b0);
        chk1("rst_scrub_fail", scrub_fail, 1'b0);
        chk1("rst_busy", busy, 1'b1);
        chk1("rst_req_ready", req_ready, 1'b0);
        tick();
        rst = 1'b0;
        count_busy(nb, nd);
        chki("reset_busy_cycles", nb, TOTAL);
        chki("reset_done_pulses", nd, 1);
        @(negedge clk);
        chk1("idle_req_ready", req_ready, 1'b1);
        tick();

        // ---- table-driven back-to-back accesses ----
        prev_rd = 1'b0;
        prev = tbl[0];
        for (int i = 0; i <= 14; i++) begin
            idle_inputs();
            if (i < 14) begin
                req_addr = tbl[i].addr;
                case (tbl[i].op)
                    OP_WR: begin req_valid = 1'b1; req_we = 1'b1; req_wdata = tbl[i].wdata; end
                    OP_RD: begin req_valid = 1'b1; end
                    default: begin rel_valid = 1'b1; rel_addr = tbl[i].addr; req_valid = 1'b1; end
                endcase
            end
            @(negedge clk);
            if (i < 14) chk1($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].op != OP_REL);
            chk1($sformatf("tbl%0d_rsp_valid", i), rsp_valid, prev_rd);
            chk1($sformatf("tbl%0d_rsp_hit", i), rsp_hit, prev_rd && prev.exp_hit);
            chkw($sformatf("tbl%0d_rsp_data", i), rsp_data, prev_rd ? prev.exp_data : '0);
            if (i < 14) begin
                prev = tbl[i];
                prev_rd = (tbl[i].op == OP_RD);
            end
            tick();
        end

        // ---- fill all, zeroize, read all back as empty ----
        for (int a = 0; a < int'(DEPTH); a++) begin
            idle_inputs();
            fill = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            req_valid = 1'b1; req_we = 1'b1; req_addr = ADDR_W'(a); req_wdata = fill;
            tick();
        end
        idle_inputs();
        zeroize = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk1("zeroize_blocks_req", req_ready, 1'b0);
        tick();
        idle_inputs();
        count_busy(nb, nd);
        chki("zeroize_busy_cycles", nb, TOTAL);
        chki("zeroize_done_pulses", nd, 1);
        for (int a = 0; a <= int'(DEPTH); a++) begin
            idle_inputs();
            if (a < int'(DEPTH)) begin req_valid = 1'b1; req_addr = ADDR_W'(a); end
            @(negedge clk);
            if (a > 0) begin
                chk1($sformatf("scrubbed%0d_rsp_valid", a - 1), rsp_valid, 1'b1);
                chk1($sformatf("scrubbed%0d_rsp_hit", a - 1), rsp_hit, 1'b0);
                chkw($sformatf("scrubbed%0d_rsp_data", a - 1), rsp_data, '0);
            end
            tick();
        end

        // ---- zeroize at pointer 7 of an ongoing scrub restarts it ----
        idle_inputs();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        count_busy(nb, nd);
        chki("restart_zeroize_busy", nb, TOTAL);
        chki("restart_zeroize_done", nd, 1);

        // ---- reset in the middle of a scrub restarts it ----
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(nb, nd);
        chki("restart_rst_busy", nb, TOTAL);
        chki("restart_rst_done", nd, 1);

`ifdef SECURE_SCRUB_READBACK_EN
        // ---- corrupt a word during VERIFY; failure is sticky until reset ----
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        for (int k = 0; k < int'(DEPTH) + 3; k++) tick();
        dut.mem_q[10] = '1;
        wait_idle();
        @(negedge clk);
        chk1("verify_fail_set", scrub_fail, 1'b1);
        tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        wait_idle();
        @(negedge clk);
        chk1("verify_fail_sticky", scrub_fail, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("verify_fail_cleared", scrub_fail, 1'b0);
        tick();
        wait_idle();
`endif

        // ---- randomized traffic against the array model ----
        begin
            int busy_left;
            logic e_rv, e_hit, e_done, z, rel, rv, we, rd_acc;
            logic [DATA_W-1:0] e_data;
            logic [ADDR_W-1:0] a, ra;
            busy_left = 0;
            e_rv = 1'b0; e_hit = 1'b0; e_done = 1'b0; e_data = '0;
            for (int cyc = 0; cyc < 800; cyc++) begin
                z   = (cyc == 0) || ($urandom_range(0, 59) == 0);
                rel = ($urandom_range(0, 5) == 0);
                rv  = ($urandom_range(0, 2) != 0);
                we  = $urandom_range(0, 1) == 1;
                a   = ADDR_W'($urandom_range(0, DEPTH - 1));
                ra  = ADDR_W'($urandom_range(0, DEPTH - 1));
                zeroize = z; rel_valid = rel; rel_addr = ra;
                req_valid = rv; req_we = we; req_addr = a;
                req_wdata = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                chk1("rnd_req_ready", req_ready, busy_left == 0 && !z && !rel);
                chk1("rnd_busy", busy, busy_left != 0);
                chk1("rnd_rsp_valid", rsp_valid, e_rv);
                chk1("rnd_rsp_hit", rsp_hit, e_hit);
                chkw("rnd_rsp_data", rsp_data, e_data);
                chk1("rnd_scrub_done", scrub_done, e_done);
`ifndef SECURE_SCRUB_READBACK_EN
                chk1("rnd_scrub_fail", scrub_fail, 1'b0);
`endif
                rd_acc = (busy_left == 0) && !z && !rel && rv && !we;
                e_rv   = rd_acc;
                e_hit  = rd_acc && m_occ[a];
                e_data = e_hit ? m_mem[a] : '0;
                e_done = (busy_left == 1) && !z;
                if (z) begin
                    for (int j = 0; j < int'(DEPTH); j++) begin
                        m_mem[j] = '0;
                        m_occ[j] = 1'b0;
                    end
                    busy_left = TOTAL;
                end else if (busy_left > 0) begin
                    busy_left--;
                end else if (rel) begin
                    m_mem[ra] = '0;
                    m_occ[ra] = 1'b0;
                end else if (rv && we) begin
                    m_mem[a] = req_wdata;
                    m_occ[a] = 1'b1;
                end
                tick();
            end
        end

        idle_inputs();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
